// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS sweep controller slice.
package dds_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    APPLY,
    DWELL,
    DONE
  } dds_state_t;

  localparam int unsigned DEF_CLOCK_FREQUENCY = 100_000_000;
  localparam int unsigned DEF_ACC_W           = 32;
  localparam int unsigned DEF_FREQ_W          = 32;
  localparam int unsigned DEF_DWELL_W         = 24;

  // Shortest dwell that still lets the next increment finish before it is applied.
  function automatic int unsigned min_dwell(input int unsigned freq_w, input int unsigned acc_w);
    return freq_w + acc_w + 2;
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Host/config and DDS-facing signals of the sweep controller.
interface dds_sweep_ctrl_if
  import dds_pkg::*;
#(
  parameter int unsigned FREQ_W  = DEF_FREQ_W,
  parameter int unsigned DWELL_W = DEF_DWELL_W,
  parameter int unsigned ACC_W   = DEF_ACC_W
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FREQ_W-1:0]  start_freq;
  logic [FREQ_W-1:0]  stop_freq;
  logic [FREQ_W-1:0]  step_freq;
  logic [DWELL_W-1:0] dwell;
  logic               loop_en;
  logic               abort;
  logic [ACC_W-1:0]   phase_inc;
  logic               inc_valid;
  logic               phase_sync;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, start_freq, stop_freq, step_freq, dwell, loop_en, abort,
    input  cfg_ready, phase_inc, inc_valid, phase_sync, busy, done
  );

  modport slave (
    input  cfg_valid, start_freq, stop_freq, step_freq, dwell, loop_en, abort,
    output cfg_ready, phase_inc, inc_valid, phase_sync, busy, done
  );
endinterface

// File: rtl/dds_inc_divider.sv
// Serial restoring divider: quotient = floor(freq * 2^ACC_W / CLOCK_FREQUENCY),
// one quotient bit per cycle, saturating to all-ones when freq >= CLOCK_FREQUENCY.
module dds_inc_divider
  import dds_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = DEF_CLOCK_FREQUENCY,
  parameter int unsigned FREQ_W          = DEF_FREQ_W,
  parameter int unsigned ACC_W           = DEF_ACC_W
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic [FREQ_W-1:0] freq,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  quotient
);
  localparam int unsigned N     = FREQ_W + ACC_W;
  localparam int unsigned REM_W = FREQ_W + 1;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [REM_W-1:0] DIVISOR = REM_W'(CLOCK_FREQUENCY);

  // num starts as the shifted numerator and fills with quotient bits from the LSB
  logic [N-1:0]     num;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] trial;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             qbit;

  always_comb begin
    trial = {rem[REM_W-2:0], num[N-1]};
    qbit  = (trial >= DIVISOR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num  <= '0;
      rem  <= '0;
      cnt  <= '0;
      sat  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        busy <= 1'b0;
      end else if (start) begin
        num  <= {freq, {ACC_W{1'b0}}};
        rem  <= '0;
        cnt  <= CNT_W'(N);
        sat  <= ({1'b0, freq} >= DIVISOR);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= qbit ? (trial - DIVISOR) : trial;
        num <= {num[N-2:0], qbit};
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = sat ? '1 : num[ACC_W-1:0];

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep sequencer: tone / one-shot / looping linear frequency sweep with
// programmable dwell, driving phase_inc and the accumulator re-sync pulse.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = DEF_CLOCK_FREQUENCY,
  parameter int unsigned ACC_W           = DEF_ACC_W,
  parameter int unsigned FREQ_W          = DEF_FREQ_W,
  parameter int unsigned DWELL_W         = DEF_DWELL_W
)(
  input logic             clk,
  input logic             rst,
  dds_sweep_ctrl_if.slave bus
);
  localparam logic [DWELL_W-1:0] MIN_DW = DWELL_W'(min_dwell(FREQ_W, ACC_W));

  dds_state_t         state;
  logic [FREQ_W-1:0]  start_r, stop_r, step_r;
  logic [FREQ_W-1:0]  pend_r;
  logic [DWELL_W-1:0] dwell_r, cnt;
  logic               loop_r, up_r, tone_r;
  logic               pend_start, applied_stop;
  logic [ACC_W-1:0]   phase_inc_r;
  logic               inc_valid_r, phase_sync_r, done_r;

  logic               div_start, div_busy, div_done;
  logic [ACC_W-1:0]   div_q;

  logic [FREQ_W:0]    sum_w, diff_w, stop_w;
  logic [FREQ_W-1:0]  stepped, after;
  logic               pend_at_stop, dwell_end, sweep_end, go_apply;

  dds_inc_divider #(
    .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
    .FREQ_W          (FREQ_W),
    .ACC_W           (ACC_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.abort),
    .start    (div_start),
    .freq     (pend_r),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // pend_r is the frequency whose increment the divider holds for the next APPLY;
  // it advances at every APPLY so the next divide overlaps the current dwell.
  always_comb begin
    stop_w  = {1'b0, stop_r};
    sum_w   = {1'b0, pend_r} + {1'b0, step_r};
    diff_w  = {1'b0, pend_r} - {1'b0, step_r};
    stepped = stop_r;
    if (up_r) begin
      if (sum_w <= stop_w) stepped = sum_w[FREQ_W-1:0];
    end else begin
      if (!diff_w[FREQ_W] && (diff_w >= stop_w)) stepped = diff_w[FREQ_W-1:0];
    end
    pend_at_stop = (pend_r == stop_r);
    after        = pend_at_stop ? start_r : stepped;
    dwell_end    = (cnt == dwell_r);
    sweep_end    = (state == DWELL) && !tone_r && dwell_end && applied_stop && !loop_r;
    go_apply     = ((state == CALC) && div_done) ||
                   ((state == DWELL) && !tone_r && dwell_end && !sweep_end && !div_busy);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      start_r      <= '0;
      stop_r       <= '0;
      step_r       <= '0;
      pend_r       <= '0;
      dwell_r      <= '0;
      cnt          <= '0;
      loop_r       <= 1'b0;
      up_r         <= 1'b0;
      tone_r       <= 1'b0;
      pend_start   <= 1'b0;
      applied_stop <= 1'b0;
      phase_inc_r  <= '0;
      inc_valid_r  <= 1'b0;
      phase_sync_r <= 1'b0;
      done_r       <= 1'b0;
      div_start    <= 1'b0;
    end else begin
      inc_valid_r  <= 1'b0;
      phase_sync_r <= 1'b0;
      done_r       <= 1'b0;
      div_start    <= 1'b0;
      if (bus.abort) begin
        state       <= IDLE;
        phase_inc_r <= '0;
      end else if (go_apply) begin
        state        <= APPLY;
        phase_inc_r  <= div_q;
        inc_valid_r  <= 1'b1;
        phase_sync_r <= pend_start;
        applied_stop <= pend_at_stop;
        pend_r       <= after;
        pend_start   <= pend_at_stop;
        div_start    <= 1'b1;
        cnt          <= DWELL_W'(1);
      end else begin
        case (state)
          IDLE: begin
            if (bus.cfg_valid) begin
              start_r    <= bus.start_freq;
              stop_r     <= bus.stop_freq;
              step_r     <= bus.step_freq;
              dwell_r    <= (bus.dwell < MIN_DW) ? MIN_DW : bus.dwell;
              loop_r     <= bus.loop_en;
              up_r       <= (bus.stop_freq >= bus.start_freq);
              tone_r     <= (bus.step_freq == '0) || (bus.start_freq == bus.stop_freq);
              pend_r     <= bus.start_freq;
              pend_start <= 1'b1;
              div_start  <= 1'b1;
              state      <= CALC;
            end
          end
          CALC: ;
          APPLY: begin
            state <= DWELL;
            cnt   <= cnt + DWELL_W'(1);
          end
          DWELL: begin
            if (sweep_end) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else if (!tone_r && !dwell_end) begin
              cnt <= cnt + DWELL_W'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cfg_ready  = (state == IDLE) && !bus.abort;
  assign bus.busy       = (state != IDLE);
  assign bus.phase_inc  = phase_inc_r;
  assign bus.inc_valid  = inc_valid_r;
  assign bus.phase_sync = phase_sync_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl at 100 MHz, 32-bit accumulator.
module tb_dds_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dds_sweep_ctrl_if #(.FREQ_W(32), .DWELL_W(24), .ACC_W(32)) bus ();

  dds_sweep_ctrl #(
    .CLOCK_FREQUENCY (100_000_000),
    .ACC_W           (32),
    .FREQ_W          (32),
    .DWELL_W         (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic drive_idle();
    bus.cfg_valid  = 1'b0;
    bus.abort      = 1'b0;
    bus.start_freq = '0;
    bus.stop_freq  = '0;
    bus.step_freq  = '0;
    bus.dwell      = '0;
    bus.loop_en    = 1'b0;
  endtask

  // Offers one config for a single clock; acc = edge index at which it was sampled.
  task automatic offer_cfg(input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] fs,
                           input logic [23:0] dw, input logic lp, output int acc, output logic rdy);
    @(negedge clk);
    bus.start_freq = f0;
    bus.stop_freq  = f1;
    bus.step_freq  = fs;
    bus.dwell      = dw;
    bus.loop_en    = lp;
    bus.cfg_valid  = 1'b1;
    #1 rdy = bus.cfg_ready;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    acc = cyc;
  endtask

  // which: 0 = inc_valid, 1 = done. Bounded wait; ok=0 on timeout.
  task automatic wait_pulse(input int which, input int max, output int at, output logic ok);
    ok = 1'b0;
    at = -100000;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if ((which == 0 && bus.inc_valid) || (which == 1 && bus.done)) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic do_abort();
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.phase_inc !== 32'd0) begin errors++; $display("FAIL reset_phase_inc: got %0d expected 0", bus.phase_inc); end
    checks++; if (bus.inc_valid !== 1'b0) begin errors++; $display("FAIL reset_inc_valid: got %b expected 0", bus.inc_valid); end
    checks++; if (bus.phase_sync !== 1'b0) begin errors++; $display("FAIL reset_phase_sync: got %b expected 0", bus.phase_sync); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", bus.cfg_ready); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tone();
    int acc, at, n;
    logic rdy, ok;
    offer_cfg(32'd1_000_000, 32'd5_000_000, 32'd0, 24'd100, 1'b0, acc, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL tone_accept: cfg_ready %b expected 1", rdy); end
    wait_pulse(0, 200, at, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tone_timeout: no inc_valid within 200 cycles"); end
    checks++; if (at - acc !== 66) begin errors++; $display("FAIL tone_latency: got %0d expected 66", at - acc); end
    checks++; if (bus.phase_inc !== 32'd42949672) begin errors++; $display("FAIL tone_inc: got %0d expected 42949672", bus.phase_inc); end
    checks++; if (bus.phase_sync !== 1'b1) begin errors++; $display("FAIL tone_sync: got %b expected 1", bus.phase_sync); end
    n = 0;
    repeat (10000) begin
      @(negedge clk);
      if (bus.inc_valid || bus.phase_sync || bus.done) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL tone_quiet: got %0d pulses expected 0", n); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL tone_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.phase_inc !== 32'd42949672) begin errors++; $display("FAIL tone_hold: got %0d expected 42949672", bus.phase_inc); end
    do_abort();
  endtask

  task automatic test_up_sweep();
    int acc, prev, at;
    logic rdy, ok;
    logic [31:0] exp_inc [3];
    exp_inc[0] = 32'd42949672;
    exp_inc[1] = 32'd85899345;
    exp_inc[2] = 32'd128849018;
    offer_cfg(32'd1_000_000, 32'd3_000_000, 32'd1_000_000, 24'd100, 1'b0, acc, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL up_accept: cfg_ready %b expected 1", rdy); end
    prev = acc;
    for (int i = 0; i < 3; i++) begin
      wait_pulse(0, 300, at, ok);
      checks++; if (at - prev !== ((i == 0) ? 66 : 100)) begin errors++; $display("FAIL up_period%0d: got %0d expected %0d", i, at - prev, (i == 0) ? 66 : 100); end
      checks++; if (bus.phase_inc !== exp_inc[i]) begin errors++; $display("FAIL up_inc%0d: got %0d expected %0d", i, bus.phase_inc, exp_inc[i]); end
      checks++; if (bus.phase_sync !== (i == 0)) begin errors++; $display("FAIL up_sync%0d: got %b expected %b", i, bus.phase_sync, i == 0); end
      prev = at;
    end
    wait_pulse(1, 300, at, ok);
    checks++; if (at - prev !== 100) begin errors++; $display("FAIL up_done_delay: got %0d expected 100", at - prev); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL up_done_width: got %b expected 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL up_idle_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL up_idle_ready: got %b expected 1", bus.cfg_ready); end
    checks++; if (bus.phase_inc !== 32'd128849018) begin errors++; $display("FAIL up_idle_inc: got %0d expected 128849018", bus.phase_inc); end
  endtask

  task automatic test_down_loop();
    int acc, prev, at;
    logic rdy, ok;
    logic [31:0] exp_inc [4];
    logic        exp_sync [4];
    exp_inc[0] = 32'd429496729; exp_sync[0] = 1'b1;
    exp_inc[1] = 32'd343597383; exp_sync[1] = 1'b0;
    exp_inc[2] = 32'd300647710; exp_sync[2] = 1'b0;
    exp_inc[3] = 32'd429496729; exp_sync[3] = 1'b1;
    offer_cfg(32'd10_000_000, 32'd7_000_000, 32'd2_000_000, 24'd10, 1'b1, acc, rdy);
    prev = acc;
    for (int i = 0; i < 4; i++) begin
      wait_pulse(0, 300, at, ok);
      checks++; if (at - prev !== 66) begin errors++; $display("FAIL loop_period%0d: got %0d expected 66", i, at - prev); end
      checks++; if (bus.phase_inc !== exp_inc[i]) begin errors++; $display("FAIL loop_inc%0d: got %0d expected %0d", i, bus.phase_inc, exp_inc[i]); end
      checks++; if (bus.phase_sync !== exp_sync[i]) begin errors++; $display("FAIL loop_sync%0d: got %b expected %b", i, bus.phase_sync, exp_sync[i]); end
      prev = at;
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL loop_busy: got %b expected 1", bus.busy); end
    do_abort();
  endtask

  task automatic test_saturation();
    int acc, at;
    logic rdy, ok;
    offer_cfg(32'd150_000_000, 32'd150_000_000, 32'd0, 24'd100, 1'b0, acc, rdy);
    wait_pulse(0, 200, at, ok);
    checks++; if (at - acc !== 66) begin errors++; $display("FAIL sat_latency: got %0d expected 66", at - acc); end
    checks++; if (bus.phase_inc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_inc: got %h expected ffffffff", bus.phase_inc); end
    do_abort();
  endtask

  task automatic test_abort();
    int acc, at, n;
    logic rdy, ok;
    offer_cfg(32'd1_000_000, 32'd3_000_000, 32'd1_000_000, 24'd100, 1'b0, acc, rdy);
    wait_pulse(0, 200, at, ok);
    repeat (30) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.phase_inc !== 32'd0) begin errors++; $display("FAIL abort_inc: got %0d expected 0", bus.phase_inc); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    bus.abort = 1'b0;
    #1;
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", bus.cfg_ready); end
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.inc_valid || bus.done || bus.busy) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", n); end
    // abort together with a config offer in IDLE: offer must be refused
    @(negedge clk);
    bus.start_freq = 32'd1_000_000;
    bus.step_freq  = 32'd0;
    bus.dwell      = 24'd100;
    bus.cfg_valid  = 1'b1;
    bus.abort      = 1'b1;
    #1;
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL abort_cfg_ready: got %b expected 0", bus.cfg_ready); end
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.abort     = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_cfg_rejected: busy %b expected 0", bus.busy); end
  endtask

  task automatic test_rst_and_busy_cfg();
    int acc, at, n;
    logic rdy, ok;
    offer_cfg(32'd3_000_000, 32'd3_000_000, 32'd0, 24'd100, 1'b0, acc, rdy);
    wait_pulse(0, 200, at, ok);
    checks++; if (bus.phase_inc !== 32'd128849018) begin errors++; $display("FAIL busycfg_first: got %0d expected 128849018", bus.phase_inc); end
    @(negedge clk);
    bus.start_freq = 32'd5_000_000;
    bus.stop_freq  = 32'd5_000_000;
    bus.cfg_valid  = 1'b1;
    #1;
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL busycfg_ready: got %b expected 0", bus.cfg_ready); end
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.inc_valid) n++;
    end
    bus.cfg_valid = 1'b0;
    checks++; if (n !== 0) begin errors++; $display("FAIL busycfg_ignored: got %0d incs expected 0", n); end
    checks++; if (bus.phase_inc !== 32'd128849018) begin errors++; $display("FAIL busycfg_hold: got %0d expected 128849018", bus.phase_inc); end
    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.phase_inc !== 32'd0) begin errors++; $display("FAIL arst_inc: got %0d expected 0", bus.phase_inc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    offer_cfg(32'd2_000_000, 32'd2_000_000, 32'd0, 24'd100, 1'b0, acc, rdy);
    repeat (20) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL calc_busy: got %b expected 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_calc_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL arst_calc_ready: got %b expected 1", bus.cfg_ready); end
    @(negedge clk);
    rst = 1'b0;
    offer_cfg(32'd4_000_000, 32'd4_000_000, 32'd0, 24'd100, 1'b0, acc, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL post_rst_accept: cfg_ready %b expected 1", rdy); end
    wait_pulse(0, 200, at, ok);
    checks++; if (at - acc !== 66) begin errors++; $display("FAIL post_rst_latency: got %0d expected 66", at - acc); end
    checks++; if (bus.phase_inc !== 32'd171798691) begin errors++; $display("FAIL post_rst_inc: got %0d expected 171798691", bus.phase_inc); end
    checks++; if (bus.phase_sync !== 1'b1) begin errors++; $display("FAIL post_rst_sync: got %b expected 1", bus.phase_sync); end
    do_abort();
  endtask

  initial begin
    test_reset();
    test_tone();
    test_up_sweep();
    test_down_loop();
    test_saturation();
    test_abort();
    test_rst_and_busy_cfg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
